// File: rtl/apb_clk_cfg_bridge.sv
// -----------------------------------------------------------------------------
// apb_clk_cfg_bridge
//
// APB slave that forwards single register accesses to one of three clock
// domain configuration ports (soc, per, cluster) over a req/ack handshake,
// and exposes a local STATUS register (synchronised lock bits and a sticky
// timeout flag, write-1-to-clear).
//
// Address map (PADDR[11:7]):
//   0 -> soc, 1 -> per, 2 -> cluster   (register index = PADDR[6:2])
//   3 with PADDR[6:0] == 0 -> STATUS   ([2:0] lock, [8] timeout flag)
//   anything else -> unmapped (PSLVERR=1, PRDATA=0)
//
// Optional feature (macro CLK_CFG_LOCK_WAIT_EN): after a write is
// acknowledged, hold the APB transfer in WAIT_LOCK until the synchronised
// lock of the written domain is high, or time out.
//
// Ports:
//   clk_i, rstn_i              clock, asynchronous active-low reset
//   PADDR/PWDATA/PWRITE/PSEL/PENABLE, PRDATA/PREADY/PSLVERR   APB slave
//   cfg_req_o[2:0]             one-hot request {cluster, per, soc}
//   cfg_ack_i[2:0]             per-domain acknowledge
//   cfg_add_o/cfg_data_o/cfg_wrn_o   shared index, write data, 1=read
//   cfg_lock_i[2:0]            per-domain lock status (asynchronous)
//   *_cfg_r_data_i             per-domain read data, valid with ack
// -----------------------------------------------------------------------------
module apb_clk_cfg_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic [11:0] PADDR,
  input  logic [31:0] PWDATA,
  input  logic        PWRITE,
  input  logic        PSEL,
  input  logic        PENABLE,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic [2:0]  cfg_req_o,
  input  logic [2:0]  cfg_ack_i,
  output logic [4:0]  cfg_add_o,
  output logic [31:0] cfg_data_o,
  output logic        cfg_wrn_o,
  input  logic [2:0]  cfg_lock_i,
  input  logic [31:0] soc_cfg_r_data_i,
  input  logic [31:0] per_cfg_r_data_i,
  input  logic [31:0] cluster_cfg_r_data_i
);

`ifdef CLK_CFG_LOCK_WAIT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2, WAIT_LOCK = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_t;
`endif

  // A wait state times out on the cycle the counter would reach TIMEOUT_CYCLES,
  // so cfg_req_o (or the lock wait) lasts exactly TIMEOUT_CYCLES cycles.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [7:0]  tmo_cnt;
  logic        tmo_flag;
  logic [2:0]  sel_q;
  logic [2:0]  lock_meta;
  logic [2:0]  lock_sync;

  logic [2:0]  dom_onehot;
  logic        is_status;
  logic        ack_hit;
  logic        tmo_hit;
  logic [31:0] rdata_mux;

  // Address decode of the current APB access.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    dom_onehot = 3'b000;
    case (PADDR[11:7])
      5'd0:    dom_onehot = 3'b001;
      5'd1:    dom_onehot = 3'b010;
      5'd2:    dom_onehot = 3'b100;
      default: dom_onehot = 3'b000;
    endcase
  end

  assign is_status = (PADDR[11:7] == 5'd3) && (PADDR[6:0] == 7'd0);

  // sel_q outlives cfg_req_o so the lock wait still knows its domain.
  assign ack_hit = |(cfg_ack_i & sel_q);
  assign tmo_hit = (tmo_cnt == TMO_LAST);

  always_comb begin
    rdata_mux = 32'd0;
    case (sel_q)
      3'b001:  rdata_mux = soc_cfg_r_data_i;
      3'b010:  rdata_mux = per_cfg_r_data_i;
      3'b100:  rdata_mux = cluster_cfg_r_data_i;
      default: rdata_mux = 32'd0;
    endcase
  end

  // Two-flop synchroniser for the asynchronous lock inputs.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rstn_i) begin
      lock_meta <= 3'b000;
      lock_sync <= 3'b000;
    end else begin
      lock_meta <= cfg_lock_i;
      lock_sync <= lock_meta;
    end
  end

`ifdef CLK_CFG_LOCK_WAIT_EN
  logic lock_hit;
  assign lock_hit = |(lock_sync & sel_q);
`endif

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state      <= IDLE;
      tmo_cnt    <= 8'd0;
      tmo_flag   <= 1'b0;
      sel_q      <= 3'b000;
      cfg_req_o  <= 3'b000;
      cfg_add_o  <= 5'd0;
      cfg_data_o <= 32'd0;
      cfg_wrn_o  <= 1'b1;
      PRDATA     <= 32'd0;
      PREADY     <= 1'b0;
      PSLVERR    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (PSEL && PENABLE) begin
            if (|dom_onehot) begin
              cfg_add_o  <= PADDR[6:2];
              cfg_data_o <= PWDATA;
              cfg_wrn_o  <= ~PWRITE;
              sel_q      <= dom_onehot;
              cfg_req_o  <= dom_onehot;
              tmo_cnt    <= 8'd0;
              state      <= REQ;
            end else if (is_status) begin
              if (PWRITE) begin
                if (PWDATA[8]) tmo_flag <= 1'b0;
              end else begin
                PRDATA <= {23'd0, tmo_flag, 5'd0, lock_sync};
              end
              PSLVERR <= 1'b0;
              PREADY  <= 1'b1;
              state   <= RESP;
            end else begin
              PRDATA  <= 32'd0;
              PSLVERR <= 1'b1;
              PREADY  <= 1'b1;
              state   <= RESP;
            end
          end
        end

        REQ: begin
          tmo_cnt <= tmo_cnt + 8'd1;
          // Ack is tested first so an ack on the timeout cycle still succeeds.
          if (ack_hit) begin
            cfg_req_o <= 3'b000;
            if (cfg_wrn_o) PRDATA <= rdata_mux;
`ifdef CLK_CFG_LOCK_WAIT_EN
            if (!cfg_wrn_o) begin
              tmo_cnt <= 8'd0;
              state   <= WAIT_LOCK;
            end else begin
              PSLVERR <= 1'b0;
              PREADY  <= 1'b1;
              state   <= RESP;
            end
`else
            PSLVERR <= 1'b0;
            PREADY  <= 1'b1;
            state   <= RESP;
`endif
          end else if (tmo_hit) begin
            cfg_req_o <= 3'b000;
            PRDATA    <= 32'd0;
            PSLVERR   <= 1'b1;
            PREADY    <= 1'b1;
            tmo_flag  <= 1'b1;
            state     <= RESP;
          end
        end

`ifdef CLK_CFG_LOCK_WAIT_EN
        WAIT_LOCK: begin
          tmo_cnt <= tmo_cnt + 8'd1;
          if (lock_hit) begin
            PSLVERR <= 1'b0;
            PREADY  <= 1'b1;
            state   <= RESP;
          end else if (tmo_hit) begin
            PRDATA   <= 32'd0;
            PSLVERR  <= 1'b1;
            PREADY   <= 1'b1;
            tmo_flag <= 1'b1;
            state    <= RESP;
          end
        end
`endif

        RESP: begin
          PREADY  <= 1'b0;
          PSLVERR <= 1'b0;
          state   <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_clk_cfg_bridge.sv
// -----------------------------------------------------------------------------
// tb_apb_clk_cfg_bridge
//
// Self-checking bench for apb_clk_cfg_bridge. An APB master task drives
// transfers; a small target model answers cfg requests after a programmable
// delay and records what the bridge presented. Expected results come from
// the bridge's behavioural rules (decode, timeout window, sticky flag).
// Builds with or without CLK_CFG_LOCK_WAIT_EN.
// -----------------------------------------------------------------------------
module tb_apb_clk_cfg_bridge;

`ifdef CLK_CFG_LOCK_WAIT_EN
  localparam int TMO       = 16;
  localparam bit LOCK_WAIT = 1'b1;
`else
  localparam int TMO       = 4;
  localparam bit LOCK_WAIT = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b1;
  logic [11:0] PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic        PWRITE = 1'b0;
  logic        PSEL = 1'b0;
  logic        PENABLE = 1'b0;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic [2:0]  cfg_req_o;
  logic [2:0]  cfg_ack_i;
  logic [4:0]  cfg_add_o;
  logic [31:0] cfg_data_o;
  logic        cfg_wrn_o;
  logic [2:0]  cfg_lock_i = 3'b111;
  logic [31:0] rd_val [3];

  apb_clk_cfg_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk_i                (clk_i),
    .rstn_i               (rstn_i),
    .PADDR                (PADDR),
    .PWDATA               (PWDATA),
    .PWRITE               (PWRITE),
    .PSEL                 (PSEL),
    .PENABLE              (PENABLE),
    .PRDATA               (PRDATA),
    .PREADY               (PREADY),
    .PSLVERR              (PSLVERR),
    .cfg_req_o            (cfg_req_o),
    .cfg_ack_i            (cfg_ack_i),
    .cfg_add_o            (cfg_add_o),
    .cfg_data_o           (cfg_data_o),
    .cfg_wrn_o            (cfg_wrn_o),
    .cfg_lock_i           (cfg_lock_i),
    .soc_cfg_r_data_i     (rd_val[0]),
    .per_cfg_r_data_i     (rd_val[1]),
    .cluster_cfg_r_data_i (rd_val[2])
  );

  always #5 clk_i = ~clk_i;

  // ---------------- target model ----------------
  int          ack_delay = 0;   // cycles req is high before ack (0 = same cycle)
  int          req_age   = 0;
  int          req_seen  = 0;
  int          unstable  = 0;
  int          multihot  = 0;
  logic [2:0]  req_first = '0;
  logic [4:0]  add_first = '0;
  logic [31:0] data_first = '0;
  logic        wrn_first = 1'b1;

  assign cfg_ack_i = (cfg_req_o != 3'b000 && req_age >= ack_delay) ? cfg_req_o : 3'b000;

  always @(posedge clk_i) begin
    if (cfg_req_o != 3'b000) begin
      if (req_age == 0) begin
        req_first  <= cfg_req_o;
        add_first  <= cfg_add_o;
        data_first <= cfg_data_o;
        wrn_first  <= cfg_wrn_o;
        req_seen   <= req_seen + 1;
      end else if (cfg_req_o !== req_first || cfg_add_o !== add_first ||
                   cfg_data_o !== data_first || cfg_wrn_o !== wrn_first) begin
        unstable <= unstable + 1;
      end
      req_age <= req_age + 1;
    end else begin
      req_age <= 0;
    end
    if (!$onehot0(cfg_req_o)) multihot <= multihot + 1;
  end

  // ---------------- checking ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One APB transfer; lat counts cycles from the first PENABLE cycle to the
  // PREADY cycle, or -1 if PREADY never came within the budget.
  task automatic apb(input logic [11:0] a, input logic [31:0] wd, input logic wr,
                     output logic [31:0] rd, output logic err, output int lat);
    @(posedge clk_i); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = a; PWDATA = wd; PWRITE = wr;
    @(posedge clk_i); #1;
    PENABLE = 1'b1;
    lat = 0; rd = '0; err = 1'b0;
    do begin
      @(posedge clk_i); #1;
      lat++;
    end while (PREADY !== 1'b1 && lat < 64);
    if (PREADY !== 1'b1) lat = -1;
    rd = PRDATA; err = PSLVERR;
    @(posedge clk_i); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] rd;
    logic        err;
    int          lat;
    int          seen0;
    int          ready_seen;
    logic        flag_m;
    logic [2:0]  lock_m;
    logic [11:0] a;
    logic [31:0] wd;
    logic        wr;
    int          kind;
    int          region;
    bit          is_dom, is_stat, timed, exp_err;
    int          exp_lat;

    flag_m = 1'b0;
    lock_m = 3'b111;
    for (int k = 0; k < 3; k++) rd_val[k] = $urandom;

    // Reset values.
    #1 rstn_i = 1'b0;
    #2;
    check("rst_req",     32'(cfg_req_o), 32'h0);
    check("rst_add",     32'(cfg_add_o), 32'h0);
    check("rst_data",    cfg_data_o,     32'h0);
    check("rst_wrn",     32'(cfg_wrn_o), 32'h1);
    check("rst_pready",  32'(PREADY),    32'h0);
    check("rst_pslverr", 32'(PSLVERR),   32'h0);
    check("rst_prdata",  PRDATA,         32'h0);
    repeat (3) @(negedge clk_i);
    rstn_i = 1'b1;
    repeat (3) @(posedge clk_i);

    // STATUS after reset: flag clear, lock bits synchronised.
    apb(12'h180, 32'h0, 1'b0, rd, err, lat);
    check("status0_data", rd, 32'h0000_0007);
    check("status0_err",  32'(err), 32'h0);
    check("status0_lat",  32'(lat), 32'd1);

    // Per read of index 2 with same-cycle ack.
    ack_delay = 0;
    rd_val[1] = 32'h0002_0003;
    seen0 = req_seen;
    apb(12'h088, 32'h0, 1'b0, rd, err, lat);
    check("per_rd_data", rd, 32'h0002_0003);
    check("per_rd_err",  32'(err), 32'h0);
    check("per_rd_lat",  32'(lat), 32'd2);
    check("per_rd_req",  32'(req_first), 32'h2);
    check("per_rd_add",  32'(add_first), 32'd2);
    check("per_rd_wrn",  32'(wrn_first), 32'h1);
    check("per_rd_cnt",  32'(req_seen - seen0), 32'd1);

    // Cluster write of index 1.
    apb(12'h104, 32'hA5A5_A5A5, 1'b1, rd, err, lat);
    check("cl_wr_req",  32'(req_first), 32'h4);
    check("cl_wr_add",  32'(add_first), 32'd1);
    check("cl_wr_wrn",  32'(wrn_first), 32'h0);
    check("cl_wr_data", data_first, 32'hA5A5_A5A5);
    check("cl_wr_err",  32'(err), 32'h0);
    check("cl_wr_lat",  32'(lat), LOCK_WAIT ? 32'd3 : 32'd2);

    // Unmapped address: immediate error, no request.
    seen0 = req_seen;
    apb(12'h400, 32'h0, 1'b0, rd, err, lat);
    check("unmap_err",  32'(err), 32'h1);
    check("unmap_data", rd, 32'h0);
    check("unmap_lat",  32'(lat), 32'd1);
    check("unmap_req",  32'(req_seen - seen0), 32'd0);

    // Timeout: target never answers; request lasts TMO cycles.
    ack_delay = 1000;
    seen0 = req_seen;
    apb(12'h010, 32'h0, 1'b0, rd, err, lat);
    check("tmo_err",  32'(err), 32'h1);
    check("tmo_data", rd, 32'h0);
    check("tmo_lat",  32'(lat), 32'(TMO + 1));
    check("tmo_req",  32'(req_seen - seen0), 32'd1);
    apb(12'h180, 32'h0, 1'b0, rd, err, lat);
    check("tmo_status", rd, 32'h0000_0107);
    apb(12'h180, 32'h0000_00FF, 1'b1, rd, err, lat);
    apb(12'h180, 32'h0, 1'b0, rd, err, lat);
    check("w1c_keep", rd, 32'h0000_0107);
    apb(12'h180, 32'h0000_0100, 1'b1, rd, err, lat);
    check("w1c_err", 32'(err), 32'h0);
    apb(12'h180, 32'h0, 1'b0, rd, err, lat);
    check("w1c_clear", rd, 32'h0000_0007);

    // Ack on the last cycle of the window wins; one cycle later is too late.
    ack_delay = TMO - 1;
    rd_val[0] = 32'h1357_9BDF;
    apb(12'h00C, 32'h0, 1'b0, rd, err, lat);
    check("late_ack_err",  32'(err), 32'h0);
    check("late_ack_data", rd, 32'h1357_9BDF);
    check("late_ack_lat",  32'(lat), 32'(TMO + 1));
    ack_delay = TMO;
    apb(12'h00C, 32'h0, 1'b0, rd, err, lat);
    check("too_late_err", 32'(err), 32'h1);
    apb(12'h180, 32'h0000_0100, 1'b1, rd, err, lat);

    // Reset while a request is outstanding.
    ack_delay = 1000;
    @(posedge clk_i); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = 12'h014; PWRITE = 1'b1; PWDATA = 32'hDEAD_BEEF;
    @(posedge clk_i); #1;
    PENABLE = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    check("mid_req_on", 32'(cfg_req_o), 32'h1);
    #2 rstn_i = 1'b0;
    #1;
    check("mid_rst_req",    32'(cfg_req_o), 32'h0);
    check("mid_rst_pready", 32'(PREADY),    32'h0);
    #2 rstn_i = 1'b1;
    PSEL = 1'b0; PENABLE = 1'b0;
    ready_seen = 0;
    repeat (6) begin
      @(posedge clk_i); #1;
      if (PREADY === 1'b1) ready_seen++;
    end
    check("mid_rst_no_ready", 32'(ready_seen), 32'd0);
    flag_m = 1'b0;
    ack_delay = 0;
    rd_val[2] = 32'h0BAD_F00D;
    apb(12'h108, 32'h0, 1'b0, rd, err, lat);
    check("post_rst_data", rd, 32'h0BAD_F00D);
    check("post_rst_err",  32'(err), 32'h0);
    check("post_rst_lat",  32'(lat), 32'd2);

`ifdef CLK_CFG_LOCK_WAIT_EN
    // Write completes only after the soc lock rises and is synchronised.
    cfg_lock_i = 3'b110;
    repeat (3) @(posedge clk_i);
    ready_seen = 0;
    fork
      apb(12'h000, 32'h1111_2222, 1'b1, rd, err, lat);
      begin
        for (int i = 0; i < 20 && cfg_req_o == 3'b000; i++) @(posedge clk_i);
        repeat (10) begin
          @(posedge clk_i); #1;
          if (PREADY === 1'b1) ready_seen++;
        end
        cfg_lock_i = 3'b111;
      end
    join
    check("lock_early_ready", 32'(ready_seen), 32'd0);
    check("lock_wait_err",    32'(err), 32'h0);
    check("lock_wait_done",   32'(lat > 0), 32'h1);
    // Lock held low: the wait times out.
    cfg_lock_i = 3'b110;
    repeat (3) @(posedge clk_i);
    apb(12'h000, 32'h3333_4444, 1'b1, rd, err, lat);
    check("lock_tmo_err", 32'(err), 32'h1);
    check("lock_tmo_lat", 32'(lat), 32'(TMO + 2));
    apb(12'h180, 32'h0, 1'b0, rd, err, lat);
    check("lock_tmo_status", rd, 32'h0000_0106);
    apb(12'h180, 32'h0000_0100, 1'b1, rd, err, lat);
    cfg_lock_i = 3'b111;
    repeat (3) @(posedge clk_i);
`endif

    // Randomised traffic against the behavioural model.
    for (int it = 0; it < 48; it++) begin
      lock_m = 3'($urandom_range(0, 7));
      cfg_lock_i = lock_m;
      repeat (3) @(posedge clk_i);
      for (int k = 0; k < 3; k++) rd_val[k] = $urandom;
      ack_delay = $urandom_range(0, TMO + 2);
      kind = $urandom_range(0, 4);
      wd = $urandom;
      case (kind)
        0, 1: begin
          a  = {3'b000, 2'($urandom_range(0, 2)), 7'($urandom)};
          wr = (kind == 1);
        end
        2: begin a = 12'h180; wr = 1'b0; end
        3: begin a = 12'h180; wr = 1'b1; end
        default: begin a = 12'($urandom); wr = 1'($urandom); end
      endcase

      region  = int'(a[11:7]);
      is_dom  = (region < 3);
      is_stat = (region == 3) && (a[6:0] == 7'd0);
      timed   = (ack_delay >= TMO);
      seen0   = req_seen;

      apb(a, wd, wr, rd, err, lat);

      if (is_dom) begin
        exp_err = timed || (LOCK_WAIT && wr && !lock_m[region]);
        if (timed)                exp_lat = TMO + 1;
        else if (LOCK_WAIT && wr) exp_lat = lock_m[region] ? ack_delay + 3 : ack_delay + 2 + TMO;
        else                      exp_lat = ack_delay + 2;
        check("rnd_dom_req",  32'(req_seen - seen0), 32'd1);
        check("rnd_dom_sel",  32'(req_first), 32'(3'b001 << region));
        check("rnd_dom_add",  32'(add_first), 32'(a[6:2]));
        check("rnd_dom_wrn",  32'(wrn_first), 32'(!wr));
        check("rnd_dom_err",  32'(err), 32'(exp_err));
        check("rnd_dom_lat",  32'(lat), 32'(exp_lat));
        if (wr)            check("rnd_dom_wdata", data_first, wd);
        if (exp_err)       check("rnd_dom_edata", rd, 32'h0);
        else if (!wr)      check("rnd_dom_rdata", rd, rd_val[region]);
        if (exp_err) flag_m = 1'b1;
      end else if (is_stat) begin
        check("rnd_st_err", 32'(err), 32'h0);
        check("rnd_st_lat", 32'(lat), 32'd1);
        if (wr) begin
          if (wd[8]) flag_m = 1'b0;
        end else begin
          check("rnd_st_data", rd, {23'd0, flag_m, 5'd0, lock_m});
        end
      end else begin
        check("rnd_um_err",  32'(err), 32'h1);
        check("rnd_um_data", rd, 32'h0);
        check("rnd_um_lat",  32'(lat), 32'd1);
        check("rnd_um_req",  32'(req_seen - seen0), 32'd0);
      end
    end

    // Whole-run handshake properties.
    check("req_onehot", 32'(multihot), 32'd0);
    check("req_stable", 32'(unstable), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
